// File: rtl/proc_pkg.sv
// Shared definitions for the memory arbiter: state encoding, default widths
// and the timeout limit used when MEM_ARB_TIMEOUT_EN is defined.
package proc_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int TIMEOUT_LIMIT = 15;
    localparam int TMR_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2,
        ST_HALTED  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Stall counter for the arbiter: counts enabled cycles and flags expiry on
// the cycle that would complete TIMEOUT_LIMIT stalled cycles.
module mem_arb_timer
    import proc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expire_o
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (cnt_en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = cnt_en_i && !clr_i && (count_q == TMR_W'(TIMEOUT_LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with
// halt handling. Optional access timeout is enabled by MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_isRd,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              err,
    output logic              halted
);

    arb_state_t        state_q;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              dm_valid_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              halted_q;
    logic              err_q;
    logic              timeout_hit;

    // Data requests always win; fetches are also blocked while halt is asserted.
    always_comb begin
        dm_gnt = (state_q == ST_IDLE) && dm_req;
        if_gnt = (state_q == ST_IDLE) && !dm_req && if_req && !halt;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic busy;
    assign busy = (state_q == ST_IF_BUSY) || (state_q == ST_DM_BUSY);

    mem_arb_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!busy || mem_rdy),
        .cnt_en_i (busy && !mem_rdy),
        .expire_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dm_gnt) begin
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= !dm_isRd;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                        state_q     <= ST_DM_BUSY;
                    end else if (if_gnt) begin
                        mem_en_q   <= 1'b1;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                        state_q    <= ST_IF_BUSY;
                    end else if (halt) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALTED;
                    end
                end
                ST_IF_BUSY, ST_DM_BUSY: begin
                    if (mem_rdy) begin
                        mem_en_q <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (state_q == ST_IF_BUSY) begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            if (!mem_wr_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                            dm_valid_q <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        // Abort: no completion pulse, captured read data untouched.
                        mem_en_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_HALTED;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign halted    = halted_q;

`ifdef MEM_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout checks follow
// MEM_ARB_TIMEOUT_EN the same way the design does.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_isRd;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [15:0] dm_rdata;
    logic        halt;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;
    logic        err;
    logic        halted;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_isRd   (dm_isRd),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .halt      (halt),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .err       (err),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_isRd = 1'b0;
        dm_addr = '0; dm_wdata = '0; halt = 1'b0; mem_rdata = '0; mem_rdy = 1'b0;
        cyc; cyc;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_valids", {if_valid, dm_valid, err}, 0);

        // Fetch granted in the first cycle after reset release, zero wait.
        rst_n = 1'b1; if_req = 1'b1; if_addr = 16'h0010;
        #1;
        chk("f_if_gnt", if_gnt, 1);
        chk("f_dm_gnt", dm_gnt, 0);
        cyc;
        if_req = 1'b0; mem_rdy = 1'b1; mem_rdata = 16'hA5C3;
        #1;
        chk("f_mem_en", mem_en, 1);
        chk("f_mem_addr", mem_addr, 16'h0010);
        chk("f_mem_wr", mem_wr, 0);
        chk("f_early_valid", if_valid, 0);
        cyc;
        mem_rdy = 1'b0;
        #1;
        chk("f_if_valid", if_valid, 1);
        chk("f_if_rdata", if_rdata, 16'hA5C3);
        chk("f_mem_en_off", mem_en, 0);
        cyc;
        chk("f_valid_pulse", if_valid, 0);

        // Simultaneous requests: store first, fetch when dm_valid pulses.
        if_req = 1'b1; if_addr = 16'h0020;
        dm_req = 1'b1; dm_isRd = 1'b0; dm_addr = 16'h8000; dm_wdata = 16'h1234;
        #1;
        chk("p_dm_gnt", dm_gnt, 1);
        chk("p_if_gnt", if_gnt, 0);
        cyc;
        dm_req = 1'b0; mem_rdy = 1'b1;
        #1;
        chk("p_mem_wr", mem_wr, 1);
        chk("p_mem_addr", mem_addr, 16'h8000);
        chk("p_mem_wdata", mem_wdata, 16'h1234);
        chk("p_if_gnt_busy", if_gnt, 0);
        cyc;
        mem_rdy = 1'b0;
        #1;
        chk("p_dm_valid", dm_valid, 1);
        chk("p_if_gnt_late", if_gnt, 1);
        chk("p_dm_rdata_store", dm_rdata, 0);
        cyc;
        if_req = 1'b0; mem_rdy = 1'b1; mem_rdata = 16'h0BEE;
        #1;
        chk("p_f_mem_addr", mem_addr, 16'h0020);
        chk("p_f_mem_wr", {mem_en, mem_wr}, 2'b10);
        chk("p_dm_valid_pulse", dm_valid, 0);
        cyc;
        mem_rdy = 1'b0;
        #1;
        chk("p_if_rdata", {15'd0, if_valid, if_rdata}, {15'd0, 1'b1, 16'h0BEE});
        cyc;

        // Load with three wait cycles.
        dm_req = 1'b1; dm_isRd = 1'b1; dm_addr = 16'h4242;
        #1;
        chk("l_dm_gnt", dm_gnt, 1);
        cyc;
        dm_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("l_wait_state", {mem_en, mem_wr, dm_valid}, 3'b100);
            chk("l_wait_addr", mem_addr, 16'h4242);
            cyc;
        end
        mem_rdy = 1'b1; mem_rdata = 16'h5A5A;
        #1;
        chk("l_last_addr", mem_addr, 16'h4242);
        cyc;
        mem_rdy = 1'b0;
        #1;
        chk("l_dm_valid", dm_valid, 1);
        chk("l_dm_rdata", dm_rdata, 16'h5A5A);
        cyc;
        chk("l_dm_valid_pulse", dm_valid, 0);

        // Reset in the middle of a load.
        dm_req = 1'b1; dm_isRd = 1'b1; dm_addr = 16'h1111;
        cyc;
        dm_req = 1'b0;
        #1;
        chk("r_mem_en_busy", mem_en, 1);
        rst_n = 1'b0;
        cyc;
        rst_n = 1'b1;
        #1;
        chk("r_mem_en", mem_en, 0);
        chk("r_dm_valid", dm_valid, 0);
        chk("r_regs_zero", {mem_addr, dm_rdata}, 0);
        cyc;
        chk("r_no_late_valid", dm_valid, 0);

        // Memory never ready.
        dm_req = 1'b1; dm_isRd = 1'b1; dm_addr = 16'h2222; mem_rdata = 16'hFFFF;
        cyc;
        dm_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            #1;
            chk("t_busy", {mem_en, err}, 2'b10);
            cyc;
        end
        chk("t_err", {err, mem_en, dm_valid}, 3'b100);
        chk("t_rdata_kept", dm_rdata, 0);
        cyc;
        chk("t_err_pulse", err, 0);
`else
        for (int i = 0; i < 100; i++) begin
            cyc;
        end
        chk("t_still_busy", {mem_en, err, dm_valid}, 3'b100);
        mem_rdy = 1'b1;
        cyc;
        mem_rdy = 1'b0;
        chk("t_done", dm_valid, 1);
        cyc;
`endif

        // Halt arriving during a fetch: fetch completes, then HALTED.
        if_req = 1'b1; if_addr = 16'h0030;
        cyc;
        if_req = 1'b0; halt = 1'b1;
        #1;
        chk("h_busy", mem_en, 1);
        cyc;
        mem_rdy = 1'b1; mem_rdata = 16'h7777;
        cyc;
        mem_rdy = 1'b0; if_req = 1'b1;
        #1;
        chk("h_if_valid", {15'd0, if_valid, if_rdata}, {15'd0, 1'b1, 16'h7777});
        chk("h_no_if_gnt", if_gnt, 0);
        chk("h_not_yet", halted, 0);
        cyc;
        dm_req = 1'b1; dm_isRd = 1'b1; halt = 1'b0;
        #1;
        chk("h_halted", halted, 1);
        for (int i = 0; i < 5; i++) begin
            chk("h_absorb", {if_gnt, dm_gnt, mem_en, halted}, 4'b0001);
            cyc;
        end
        if_req = 1'b0; dm_req = 1'b0; rst_n = 1'b0;
        cyc;
        rst_n = 1'b1;
        #1;
        chk("h_rst_release", halted, 0);

        // Halt in IDLE still grants a data request.
        halt = 1'b1; dm_req = 1'b1; dm_isRd = 1'b0; dm_addr = 16'h0042; dm_wdata = 16'hBEEF;
        if_req = 1'b1;
        #1;
        chk("hi_gnts", {dm_gnt, if_gnt}, 2'b10);
        cyc;
        dm_req = 1'b0; if_req = 1'b0; mem_rdy = 1'b1;
        #1;
        chk("hi_store", {mem_en, mem_wr, mem_wdata}, {2'b11, 16'hBEEF});
        cyc;
        mem_rdy = 1'b0;
        cyc;
        chk("hi_halted", halted, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
